// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: MEM stage driving a 16-bit async SRAM as two half-word accesses with wait states.
// Revision: 1.0
`default_nettype none

module mem_stage_sram_ctrl #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbEnIn,
  input  logic        memREnIn,
  input  logic        memWEnIn,
  input  logic [31:0] aluResIn,
  input  logic [31:0] valRmIn,
  input  logic [3:0]  destIn,
  input  logic [31:0] instruction_in,
  output logic        wbEnOut,
  output logic        memREnOut,
  output logic [31:0] aluResOut,
  output logic [3:0]  destOut,
  output logic [31:0] instruction_out,
  output logic [31:0] memDataOut,
  output logic        ready,
  output logic [16:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WR_LO = 3'd3,
    S_WR_HI = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_data_q, mem_data_d;

  logic        req;
  logic        hi;
  logic        borrow;
  logic [15:0] word_addr;

  assign req = memREnIn | memWEnIn;

  // Bits [17:2] of (aluResIn - ADDR_BASE), with the borrow out of the dropped low two bits.
  assign borrow    = (aluResIn[1:0] < ADDR_BASE[1:0]);
  assign word_addr = aluResIn[17:2] - ADDR_BASE[17:2] - {15'd0, borrow};

  assign hi        = (state_q == S_RD_HI) || (state_q == S_WR_HI);
  assign sram_addr = {word_addr, hi};

  assign wbEnOut         = wbEnIn;
  assign memREnOut       = memREnIn;
  assign aluResOut       = aluResIn;
  assign destOut         = destIn;
  assign instruction_out = instruction_in;
  assign memDataOut      = mem_data_q;

  assign ready = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);

  always_comb begin
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = 16'd0;
    if (state_q == S_WR_LO) begin
      sram_we_n   = 1'b0;
      sram_dq_oe  = 1'b1;
      sram_dq_out = valRmIn[15:0];
    end else if (state_q == S_WR_HI) begin
      sram_we_n   = 1'b0;
      sram_dq_oe  = 1'b1;
      sram_dq_out = valRmIn[31:16];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_data_d = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = memREnIn ? S_RD_LO : S_WR_LO;
          cnt_d   = 4'd0;
        end
      end
      S_RD_LO, S_RD_HI, S_WR_LO, S_WR_HI: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = 4'd0;
          case (state_q)
            S_RD_LO: begin
              mem_data_d[15:0] = sram_dq_in;
              state_d          = S_RD_HI;
            end
            S_RD_HI: begin
              mem_data_d[31:16] = sram_dq_in;
              state_d           = S_DONE;
            end
            S_WR_LO: state_d = S_WR_HI;
            default: state_d = S_DONE;
          endcase
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      // Upstream still presents the completing instruction here, so req must be ignored.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      mem_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed testbench for mem_stage_sram_ctrl with a behavioural 16-bit SRAM model.
`default_nettype none

module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wbEnIn = 1'b0, memREnIn = 1'b0, memWEnIn = 1'b0;
  logic [31:0] aluResIn = 32'd0, valRmIn = 32'd0, instruction_in = 32'd0;
  logic [3:0]  destIn = 4'd0;
  logic        wbEnOut, memREnOut, ready, sram_dq_oe, sram_we_n;
  logic [31:0] aluResOut, instruction_out, memDataOut;
  logic [3:0]  destOut;
  logic [16:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  logic [15:0] sram [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.WAIT_CYCLES(5), .ADDR_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst),
    .wbEnIn(wbEnIn), .memREnIn(memREnIn), .memWEnIn(memWEnIn),
    .aluResIn(aluResIn), .valRmIn(valRmIn), .destIn(destIn),
    .instruction_in(instruction_in),
    .wbEnOut(wbEnOut), .memREnOut(memREnOut), .aluResOut(aluResOut),
    .destOut(destOut), .instruction_out(instruction_out),
    .memDataOut(memDataOut), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  assign sram_dq_in = sram[sram_addr[7:0]];

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram[sram_addr[7:0]] <= sram_dq_out;
  end

  task automatic drive(input logic re, input logic we, input logic wb,
                       input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest);
    memREnIn       = re;
    memWEnIn       = we;
    wbEnIn         = wb;
    aluResIn       = alu;
    valRmIn        = val;
    destIn         = dest;
    instruction_in = {alu[15:0], val[15:0]};
  endtask

  // Counts negedges with ready low until ready goes high (DONE); bounded.
  task automatic wait_done(output int lows, output bit ok);
    lows = 0;
    ok   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
      lows++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
    repeat (3) @(negedge clk);
    checks++;
    if (memDataOut !== 32'd0) begin
      errors++; $display("FAIL reset_memdata: got %h expected %h", memDataOut, 32'd0);
    end
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: got we_n=%b oe=%b expected we_n=1 oe=0", sram_we_n, sram_dq_oe);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_req: got %b expected 0", ready);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_idle: got %b expected 1", ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_idle: got %b expected 1", ready);
    end
  endtask

  task automatic test_store;
    int lows;
    bit ok;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 4'd0);
    wait_done(lows, ok);
    checks++;
    if (!ok || lows != 11) begin
      errors++; $display("FAIL store_ready_low: got %0d cycles (done=%0d) expected 11", lows, ok);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checks++;
    if (sram[0] !== 16'hBEEF) begin
      errors++; $display("FAIL store_lo: got %h expected %h", sram[0], 16'hBEEF);
    end
    checks++;
    if (sram[1] !== 16'hDEAD) begin
      errors++; $display("FAIL store_hi: got %h expected %h", sram[1], 16'hDEAD);
    end
    checks++;
    if (memDataOut !== 32'd0) begin
      errors++; $display("FAIL store_memdata_kept: got %h expected %h", memDataOut, 32'd0);
    end
  endtask

  task automatic test_load;
    int lows;
    bit ok;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 32'd1024, 32'd0, 4'd5);
    wait_done(lows, ok);
    checks++;
    if (!ok || lows != 11) begin
      errors++; $display("FAIL load_ready_low: got %0d cycles (done=%0d) expected 11", lows, ok);
    end
    checks++;
    if (memDataOut !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_data: got %h expected %h", memDataOut, 32'hDEADBEEF);
    end
    // Inputs held past DONE: ready must drop again as the held request is re-accepted.
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL load_ready_once: got %b expected 0", ready);
    end
    wait_done(lows, ok);
    checks++;
    if (!ok || lows != 10) begin
      errors++; $display("FAIL load_repeat_low: got %0d cycles (done=%0d) expected 10", lows, ok);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic test_nonmem;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h12345678, 32'h0BADF00D, 4'd3);
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL nonmem_ready: got %b expected 1", ready);
    end
    checks++;
    if (aluResOut !== 32'h12345678 || destOut !== 4'd3 || wbEnOut !== 1'b1 || memREnOut !== 1'b0) begin
      errors++; $display("FAIL nonmem_passthru: got alu=%h dest=%h wb=%b re=%b expected alu=12345678 dest=3 wb=1 re=0",
                         aluResOut, destOut, wbEnOut, memREnOut);
    end
    checks++;
    if (instruction_out !== 32'h5678F00D) begin
      errors++; $display("FAIL nonmem_instr: got %h expected %h", instruction_out, 32'h5678F00D);
    end
    @(negedge clk);
    checks++;
    if (sram_we_n !== 1'b1 || memDataOut !== 32'hDEADBEEF) begin
      errors++; $display("FAIL nonmem_side_effects: got we_n=%b data=%h expected we_n=1 data=deadbeef", sram_we_n, memDataOut);
    end
  endtask

  task automatic test_back_to_back;
    int lows;
    bit ok;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0000CAFE, 4'd0);
    wait_done(lows, ok);
    checks++;
    if (!ok || lows != 11) begin
      errors++; $display("FAIL b2b_store_low: got %0d cycles (done=%0d) expected 11", lows, ok);
    end
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd7);
    wait_done(lows, ok);
    checks++;
    if (!ok || lows != 11) begin
      errors++; $display("FAIL b2b_load_low: got %0d cycles (done=%0d) expected 11", lows, ok);
    end
    checks++;
    if (memDataOut !== 32'h0000CAFE) begin
      errors++; $display("FAIL b2b_load_data: got %h expected %h", memDataOut, 32'h0000CAFE);
    end
    checks++;
    if (sram[2] !== 16'hCAFE || sram[3] !== 16'h0000) begin
      errors++; $display("FAIL b2b_sram: got %h_%h expected 0000_cafe", sram[3], sram[2]);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic test_reset_mid_write;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'd1032, 32'h11112222, 4'd0);
    repeat (7) @(posedge clk);
    #2;
    checks++;
    if (sram_we_n !== 1'b0 || sram_addr !== 17'd5 || sram_dq_out !== 16'h1111) begin
      errors++; $display("FAIL midwr_in_wr_hi: got we_n=%b addr=%0d dq=%h expected we_n=0 addr=5 dq=1111",
                         sram_we_n, sram_addr, sram_dq_out);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL midwr_strobe_off: got we_n=%b oe=%b expected we_n=1 oe=0", sram_we_n, sram_dq_oe);
    end
    checks++;
    if (sram[4] !== 16'h2222 || memDataOut !== 32'd0) begin
      errors++; $display("FAIL midwr_state: got sram4=%h data=%h expected sram4=2222 data=0", sram[4], memDataOut);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL midwr_ready_req: got %b expected 0", ready);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL midwr_ready_idle: got %b expected 1", ready);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
      errors++; $display("FAIL midwr_idle_after: got ready=%b we_n=%b expected 1 1", ready, sram_we_n);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_nonmem();
    test_back_to_back();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory-access stage of the pipelined ARM core, directly upstream of the MEM→WB pipeline register. It runs data-memory loads and stores against an external 16-bit asynchronous SRAM as two half-word accesses with programmable wait states. It stalls the pipeline until each access completes, then presents the load result and the passed-through control fields for the MEM→WB register to capture.

## Interface
- `WAIT_CYCLES`, default 5: cycles per half-word SRAM access; legal range 1–15.
- `ADDR_BASE`, default 1024: byte address that maps to SRAM word 0.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `wbEnIn`, `memREnIn`, `memWEnIn`  in  1 each  write-back enable, load request, store request from the EXE→MEM register.
- `aluResIn`  in  32  effective byte address, or the ALU result for non-memory instructions.
- `valRmIn`  in  32  store data.
- `destIn`  in  4  destination register.
- `instruction_in`  in  32  instruction word, carried for debug.
- `wbEnOut`, `memREnOut`  out  1 each  combinational pass-through of `wbEnIn` and `memREnIn`.
- `aluResOut`  out  32  pass-through of `aluResIn`.
- `destOut`  out  4  pass-through of `destIn`.
- `instruction_out`  out  32  pass-through of `instruction_in`.
- `memDataOut`  out  32  registered load result.
- `ready`  out  1  high when the stage may advance this cycle; low freezes PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- `sram_addr`  out  17  SRAM half-word address.
- `sram_dq_out`  out  16  write data.
- `sram_dq_in`  in  16  read data.
- `sram_dq_oe`  out  1  high drives the data bus.
- `sram_we_n`  out  1  active-low write strobe.

## Operation
- Request condition: `req = memREnIn | memWEnIn`. If both are high (illegal), the load wins.
- Address mapping:
  - `off = aluResIn - ADDR_BASE`, 32-bit wrap-around arithmetic.
  - `sram_addr = {off[17:2], hi}`, where `hi = 1` in the HI states and 0 otherwise.
  - `off[1:0]` is ignored; there is no range check.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - IDLE, `req` low: `ready = 1`; stay in IDLE.
  - IDLE, `req` high: `ready = 0`; go to RD_LO for a load, WR_LO for a store; clear `cnt`.
  - RD_LO, RD_HI, WR_LO, WR_HI: a 4-bit `cnt` counts 0 to `WAIT_CYCLES-1`.
  - At `cnt == WAIT_CYCLES-1`:
    - RD_LO captures `sram_dq_in` into `memDataOut[15:0]`, then goes to RD_HI.
    - RD_HI captures `sram_dq_in` into `memDataOut[31:16]`, then goes to DONE.
    - WR_LO goes to WR_HI.
    - WR_HI goes to DONE.
    - `cnt` clears on every state change.
  - DONE: `ready = 1` for exactly one cycle, then go to IDLE unconditionally. `req` is ignored here, because upstream inputs still hold the instruction that is completing.
- Write drive, only in WR_LO and WR_HI:
  - `sram_we_n = 0` and `sram_dq_oe = 1`.
  - `sram_dq_out` is `valRmIn[15:0]` in WR_LO and `valRmIn[31:16]` in WR_HI.
- All other states: `sram_we_n = 1`, `sram_dq_oe = 0`, `sram_dq_out = 0`.
- `memDataOut` holds its value until the next load overwrites it. Stores and non-memory instructions leave it unchanged.
- Upstream holds all inputs stable while `ready = 0`. The block does not latch them.

## Timing
- Reset (asynchronous, `rst` low), effective immediately:
  - state = IDLE, `cnt` = 0, `memDataOut` = 0.
  - `sram_we_n` = 1, `sram_dq_oe` = 0.
  - `ready` follows `req`, since pass-through outputs still follow their inputs.
- Reset asserted mid-access aborts the access. The write strobe deasserts in the same cycle, and the half already written stays in SRAM.
- Non-memory instruction: zero stall; `ready = 1` in the same cycle.
- Memory access: `ready` is low for `1 + 2*WAIT_CYCLES` cycles, then high for one cycle in DONE. The MEM→WB register captures on the edge that ends DONE, so total occupancy is `2*WAIT_CYCLES + 2` cycles.
- The load result is valid in `memDataOut` from the DONE cycle onward.
- Back-to-back memory instructions: the second one arrives in IDLE on the cycle after DONE and starts with no extra bubble.
- `sram_addr` is combinational from `aluResIn` and state. It is stable for the whole access because the inputs are frozen.

## Test plan
- Reset: hold `rst = 0` with random inputs → `memDataOut = 0`, `sram_we_n = 1`, `sram_dq_oe = 0`; state returns to IDLE.
- Store, `WAIT_CYCLES = 5`, `aluResIn = 1024`, `valRmIn = 0xDEADBEEF`:
  - SRAM model shows addr 0 = 0xBEEF, addr 1 = 0xDEAD.
  - `ready` is low for 11 cycles, then high for 1 cycle.
- Load from `aluResIn = 1024` after the store → `memDataOut = 0xDEADBEEF` in DONE; `ready` is high exactly once.
- Non-memory instruction with `aluResIn = 0x12345678`, `wbEnIn = 1`, `destIn = 3` → `ready = 1`; the outputs mirror the inputs in the same cycle; `sram_we_n` stays 1.
- Back-to-back: store to 1028 (`valRmIn = 0x0000CAFE`), then a load from 1028 on the next cycle → SRAM addr 2/3 written; load returns 0x0000CAFE; no idle cycle between the two accesses.
- Reset mid-write: assert `rst` low during WR_HI cycle 2 → `sram_we_n = 1` immediately; after release, state is IDLE and `ready` follows `req`.
